booth_radix4_seq: RTL and testbench
===================================

# booth_radix4_seq

Sequential, parametrised radix-4 Booth multiplier. It generalises the existing fixed 4x4 signed Booth multiplier to any even operand width, adds a per-operation signed/unsigned mode, and uses valid/ready handshakes on input and output. It retires one Booth partial product per clock into a shared accumulator, trading latency for area. It sits on the datapath wherever a WIDTH x WIDTH multiply with full 2*WIDTH-bit result is needed.

## Interface
- WIDTH, 8, operand width in bits; must be even and >= 4.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_valid  input  1  operands and mode valid.
- start_ready  output  1  block can accept operands; high only in IDLE.
- signed_mode  input  1  1 = both operands two's complement, 0 = both unsigned.
- x  input  WIDTH  multiplicand.
- multiplier  input  WIDTH  multiplier.
- result  output  2*WIDTH  product, exact.
- result_valid  output  1  result holds a completed product.
- result_ready  input  1  downstream accepts result.
- busy  output  1  high in CALC or DONE.

## Operation
- States:
  - IDLE: start_ready=1.
  - CALC: iterating.
  - DONE: result_valid=1.
- Accept: start_valid && start_ready at a rising edge. The edge captures x, multiplier and signed_mode into internal registers, clears the accumulator and digit counter to 0, and moves IDLE->CALC. Input changes after the accept edge are ignored.
- Operand extension to WIDTH+2 bits: sign-extend when signed_mode=1, zero-extend when signed_mode=0. This applies to both the multiplicand (Xe) and the multiplier (Me).
- Digit groups: append 0 below Me's LSB, giving WIDTH+3 bits. Group i = bits {2i+1, 2i, 2i-1} of the padded Me, for i = 0..WIDTH/2.
  - Total digits: NDIG = WIDTH/2+1.
- Digit encoding:
  - 000 and 111 -> 0
  - 001 and 010 -> +1
  - 011 -> +2
  - 100 -> -2
  - 101 and 110 -> -1
- Each CALC edge: acc <= acc + (digit_i * Xe) << 2i, then counter <= counter+1.
  - acc is signed, 2*WIDTH+4 bits; all addition is two's complement.
  - Negative digits are formed as the inverted operand plus carry-in 1.
- When the counter reaches NDIG-1, that same edge adds the last digit, loads result with acc_next[2*WIDTH-1:0], and moves CALC->DONE.
- The discarded upper acc bits are pure sign/zero extension. The product is exact in both modes. In signed mode the top digit is always 0.
- DONE: result_valid=1 and result is stable. On result_valid && result_ready at an edge, move DONE->IDLE.
  - No new accept happens in DONE; start_ready=0 there.
  - start_ready rises the cycle after the result handoff.
- result is not cleared on handoff. It holds the last product until the next DONE entry.
- busy = (state != IDLE).

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, acc=0, result=0.
  - result_valid=0, busy=0.
  - start_ready=1 once rst is high.
- Reset asserted mid-CALC or in DONE aborts the operation immediately. There is no partial result, and result_valid drops asynchronously.
- Latency: accept at edge E0 gives result_valid=1 after edge E0+NDIG. For WIDTH=8 this is 5 cycles; for WIDTH=4 it is 3.
- Throughput with result_ready tied 1: one product per NDIG+2 cycles (accept, NDIG CALC cycles, DONE handoff, back in IDLE).
- Backpressure: DONE persists indefinitely while result_ready=0. result and result_valid stay unchanged.
- result_ready asserted while not in DONE is ignored. start_valid outside IDLE is ignored, so operands must be held until accepted.
- Outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, signed_mode=1, x=0x80 (-128), multiplier=0x80 -> after 5 cycles result=0x4000, result_valid=1.
- WIDTH=8, signed_mode=0, x=0xFF, multiplier=0xFF -> result=0xFE01. Same operands with signed_mode=1 -> result=0x0001.
- WIDTH=8, signed, x=0xFF (-1), multiplier=0x7F -> result=0xFF81. Hold result_ready=0 for 10 cycles -> result, result_valid and busy unchanged and start_ready=0. Release -> start_ready=1 the cycle after the handoff.
- WIDTH=8, accept x=0x12, multiplier=0x34; pulse rst low in the 2nd CALC cycle -> result=0, result_valid=0, state IDLE. Next operation x=3, multiplier=5, unsigned -> result=0x000F.
- WIDTH=4, signed, x=0x8 (-8), multiplier=0x7 -> result=0xC8 after 3 cycles. Then run an exhaustive sweep of all 256 operand pairs in both modes against a reference model, with result_ready randomised.
- WIDTH=16, unsigned, x=0xFFFF, multiplier=0xFFFF -> result=0xFFFE0001 after 9 cycles. Change the input operands during CALC -> result unaffected.

Source files
------------

// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier: one partial product per clock into a shared
// accumulator, exact 2*WIDTH-bit result in signed or unsigned mode, valid/ready on both sides.
module booth_radix4_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int MW   = WIDTH + 3;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [AW-1:0]      acc_reg, acc_next;
  logic [AW-1:0]      xs_reg, xs_next;
  logic [MW-1:0]      mp_reg, mp_next;
  logic [2*WIDTH-1:0] result_reg, result_next;

  logic               pp_neg, pp_two, pp_zero;
  logic [AW-1:0]      pp_mag, addend, acc_sum;

  // xs_reg holds the extended multiplicand pre-shifted to the current digit weight;
  // mp_reg shifts right so the current Booth group always sits in bits [2:0].
  always_comb begin
    pp_neg  = 1'b0;
    pp_two  = 1'b0;
    pp_zero = 1'b0;
    case (mp_reg[2:0])
      3'b000, 3'b111: pp_zero = 1'b1;
      3'b011:         pp_two  = 1'b1;
      3'b100:         begin pp_two = 1'b1; pp_neg = 1'b1; end
      3'b101, 3'b110: pp_neg  = 1'b1;
      default:        ;
    endcase
    pp_mag  = pp_zero ? '0 : (pp_two ? (xs_reg << 1) : xs_reg);
    addend  = pp_neg ? ~pp_mag : pp_mag;
    acc_sum = acc_reg + addend + AW'(pp_neg);
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    xs_next     = xs_reg;
    mp_next     = mp_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          state_next = CALC;
          cnt_next   = '0;
          acc_next   = '0;
          xs_next    = {{(WIDTH+4){signed_mode & x[WIDTH-1]}}, x};
          mp_next    = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier, 1'b0};
        end
      end
      CALC: begin
        acc_next = acc_sum;
        cnt_next = cnt_reg + 1'b1;
        xs_next  = xs_reg << 2;
        mp_next  = mp_reg >> 2;
        if (cnt_reg == LAST) begin
          result_next = acc_sum[2*WIDTH-1:0];
          state_next  = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      xs_reg     <= '0;
      mp_reg     <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      xs_reg     <= xs_next;
      mp_reg     <= mp_next;
      result_reg <= result_next;
    end
  end

  assign start_ready  = (state_reg == IDLE);
  assign result_valid = (state_reg == DONE);
  assign busy         = (state_reg != IDLE);
  assign result       = result_reg;

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Directed bench for booth_radix4_seq at WIDTH 4, 8 and 16, plus an exhaustive
// 4-bit sweep against a behavioural multiply.
module tb_booth_radix4_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] xin = '0;
  logic [15:0] yin = '0;
  logic        smode = 1'b0;
  logic        sv4 = 1'b0, sv8 = 1'b0, sv16 = 1'b0;
  logic        rr4 = 1'b0, rr8 = 1'b0, rr16 = 1'b0;
  logic        sr4, sr8, sr16, rv4, rv8, rv16, busy4, busy8, busy16;
  logic [7:0]  res4;
  logic [15:0] res8;
  logic [31:0] res16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_radix4_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4), .signed_mode(smode),
    .x(xin[3:0]), .multiplier(yin[3:0]), .result(res4), .result_valid(rv4),
    .result_ready(rr4), .busy(busy4));

  booth_radix4_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8), .signed_mode(smode),
    .x(xin[7:0]), .multiplier(yin[7:0]), .result(res8), .result_valid(rv8),
    .result_ready(rr8), .busy(busy8));

  booth_radix4_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start_valid(sv16), .start_ready(sr16), .signed_mode(smode),
    .x(xin), .multiplier(yin), .result(res16), .result_valid(rv16),
    .result_ready(rr16), .busy(busy16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rv(input int w);
    case (w)
      4:       return rv4;
      8:       return rv8;
      default: return rv16;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int w);
    case (w)
      4:       return {24'b0, res4};
      8:       return {16'b0, res8};
      default: return res16;
    endcase
  endfunction

  task automatic set_sv(input int w, input logic v);
    case (w)
      4:       sv4 = v;
      8:       sv8 = v;
      default: sv16 = v;
    endcase
  endtask

  task automatic set_rr(input int w, input logic v);
    case (w)
      4:       rr4 = v;
      8:       rr8 = v;
      default: rr16 = v;
    endcase
  endtask

  // Accept one operation, scramble the inputs right after the accept edge,
  // then count edges until result_valid (bounded).
  task automatic run_op(input int w, input logic sm, input logic [15:0] a,
                        input logic [15:0] b, output int lat);
    @(negedge clk);
    xin = a; yin = b; smode = sm;
    set_sv(w, 1'b1);
    @(posedge clk);
    #1;
    set_sv(w, 1'b0);
    xin = ~a; yin = b ^ 16'h5A5A; smode = ~sm;
    lat = 0;
    while (!get_rv(w) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff(input int w, input string tag);
    @(negedge clk);
    set_rr(w, 1'b1);
    @(posedge clk);
    #1;
    set_rr(w, 1'b0);
    check({tag, " start_ready after handoff"}, {31'b0, (w == 4) ? sr4 : (w == 8) ? sr8 : sr16}, 32'd1);
  endtask

  initial begin
    int lat;
    int g;
    int ea, eb, prod;
    logic [31:0] exp;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset rv8", {31'b0, rv8}, 32'd0);
    check("reset busy8", {31'b0, busy8}, 32'd0);
    check("reset res8", get_res(8), 32'd0);
    check("reset res4", get_res(4), 32'd0);
    check("reset res16", get_res(16), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset start_ready8", {31'b0, sr8}, 32'd1);

    // W8 signed -128 * -128
    run_op(8, 1'b1, 16'h0080, 16'h0080, lat);
    check("w8 s 80*80 latency", lat, 32'd5);
    check("w8 s 80*80 rv", {31'b0, rv8}, 32'd1);
    check("w8 s 80*80 result", get_res(8), 32'h4000);
    handoff(8, "w8 s 80*80");

    // W8 unsigned and signed FF*FF; result holds after handoff
    run_op(8, 1'b0, 16'h00FF, 16'h00FF, lat);
    check("w8 u FF*FF result", get_res(8), 32'hFE01);
    handoff(8, "w8 u FF*FF");
    check("w8 result held after handoff", get_res(8), 32'hFE01);
    run_op(8, 1'b1, 16'h00FF, 16'h00FF, lat);
    check("w8 s FF*FF result", get_res(8), 32'h0001);
    handoff(8, "w8 s FF*FF");

    // W8 signed -1 * 127 with 10 cycles of backpressure
    run_op(8, 1'b1, 16'h00FF, 16'h007F, lat);
    check("w8 s FF*7F result", get_res(8), 32'hFF81);
    repeat (10) @(posedge clk);
    #1;
    check("w8 bp result", get_res(8), 32'hFF81);
    check("w8 bp rv", {31'b0, rv8}, 32'd1);
    check("w8 bp busy", {31'b0, busy8}, 32'd1);
    check("w8 bp start_ready", {31'b0, sr8}, 32'd0);
    handoff(8, "w8 bp");
    check("w8 busy after handoff", {31'b0, busy8}, 32'd0);

    // W8 reset in the 2nd CALC cycle
    @(negedge clk);
    xin = 16'h0012; yin = 16'h0034; smode = 1'b1;
    sv8 = 1'b1;
    @(posedge clk);
    #1;
    sv8 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("w8 abort rv", {31'b0, rv8}, 32'd0);
    check("w8 abort result", get_res(8), 32'd0);
    check("w8 abort busy", {31'b0, busy8}, 32'd0);
    check("w8 abort start_ready", {31'b0, sr8}, 32'd1);
    #1;
    rst = 1'b1;
    run_op(8, 1'b0, 16'h0003, 16'h0005, lat);
    check("w8 u 3*5 latency", lat, 32'd5);
    check("w8 u 3*5 result", get_res(8), 32'h000F);
    handoff(8, "w8 u 3*5");

    // W4 signed -8 * 7
    run_op(4, 1'b1, 16'h0008, 16'h0007, lat);
    check("w4 s 8*7 latency", lat, 32'd3);
    check("w4 s 8*7 result", get_res(4), 32'h00C8);
    handoff(4, "w4 s 8*7");

    // W4 exhaustive sweep, both modes, random result_ready
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          ea = (s == 1 && a >= 8) ? a - 16 : a;
          eb = (s == 1 && b >= 8) ? b - 16 : b;
          prod = ea * eb;
          exp = {24'b0, 8'(prod)};
          @(negedge clk);
          rr4 = 1'($urandom_range(0, 1));
          run_op(4, 1'(s), 16'(a), 16'(b), lat);
          check($sformatf("w4 sweep s=%0d %0d*%0d", s, a, b), get_res(4), exp);
          g = 0;
          while (rv4 && g < 60) begin
            @(negedge clk);
            rr4 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            g++;
          end
          rr4 = 1'b0;
          check($sformatf("w4 sweep handoff s=%0d %0d*%0d", s, a, b), {31'b0, rv4}, 32'd0);
        end
      end
    end

    // W16 unsigned FFFF*FFFF (inputs scrambled during CALC by run_op)
    run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, lat);
    check("w16 u FFFF*FFFF latency", lat, 32'd9);
    check("w16 u FFFF*FFFF result", get_res(16), 32'hFFFE0001);
    handoff(16, "w16 u FFFF*FFFF");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
